// File: rtl/oram_port_arbiter.sv
// Round-robin front door that multiplexes NumPorts requesters onto one ORAM
// command/store/load interface, one outstanding command at a time, and steers
// exactly one block of store or load beats to or from the granted port.
module oram_port_arbiter #(
  parameter int NumPorts   = 4,
  parameter int ORAMU      = 32,
  parameter int BECMDWidth = 2,
  parameter int FEDWidth   = 64,
  parameter int BlockBeats = 8,
  parameter int PortWidth  = (NumPorts > 1) ? $clog2(NumPorts) : 1
) (
  input  logic                           Clock_i,
  input  logic                           Reset_ni,
  input  logic [NumPorts*BECMDWidth-1:0] Cmd_i,
  input  logic [NumPorts*ORAMU-1:0]      PAddr_i,
  input  logic [NumPorts-1:0]            CmdValid_i,
  output logic [NumPorts-1:0]            CmdReady_o,
  input  logic [NumPorts*FEDWidth-1:0]   DataIn_i,
  input  logic [NumPorts-1:0]            DataInValid_i,
  output logic [NumPorts-1:0]            DataInReady_o,
  output logic [FEDWidth-1:0]            DataOut_o,
  output logic [NumPorts-1:0]            DataOutValid_o,
  input  logic [NumPorts-1:0]            DataOutReady_i,
  output logic [BECMDWidth-1:0]          OCmd_o,
  output logic [ORAMU-1:0]               OPAddr_o,
  output logic                           OCmdValid_o,
  input  logic                           OCmdReady_i,
  output logic [FEDWidth-1:0]            OStoreData_o,
  output logic                           OStoreValid_o,
  input  logic                           OStoreReady_i,
  input  logic [FEDWidth-1:0]            OLoadData_i,
  input  logic                           OLoadValid_i,
  output logic                           OLoadReady_o,
  output logic [PortWidth-1:0]           ActivePort_o,
  output logic                           Busy_o
);

  localparam int BeatWidth = (BlockBeats > 1) ? $clog2(BlockBeats) : 1;
  localparam logic [BeatWidth-1:0]  LastBeat     = BeatWidth'(BlockBeats - 1);
  localparam logic [PortWidth-1:0]  LastPort     = PortWidth'(NumPorts - 1);
  localparam logic [BECMDWidth-1:0] BECMD_Read   = BECMDWidth'(2);
  localparam logic [BECMDWidth-1:0] BECMD_ReadRmv = BECMDWidth'(3);

  typedef enum logic [1:0] {IDLE, ISSUE, STORE, LOAD} state_e;

  state_e                  state_q, state_d;
  logic [PortWidth-1:0]    ptr_q, ptr_d;
  logic [PortWidth-1:0]    active_q, active_d;
  logic [BeatWidth-1:0]    cnt_q, cnt_d;
  logic [BECMDWidth-1:0]   ocmd_q, ocmd_d;
  logic [ORAMU-1:0]        opaddr_q, opaddr_d;

  logic                    grant_found;
  logic [PortWidth-1:0]    grant_idx;
  logic                    beat_fire;
  logic                    is_load;
  int                      cand;

  // Search upward from the pointer with wrap; scanning offsets high-to-low
  // lets the nearest requester overwrite any farther one.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int i = NumPorts - 1; i >= 0; i--) begin
      cand = (int'(ptr_q) + i) % NumPorts;
      if (CmdValid_i[cand]) begin
        grant_found = 1'b1;
        grant_idx   = PortWidth'(cand);
      end
    end
  end

  assign is_load = (ocmd_q == BECMD_Read) || (ocmd_q == BECMD_ReadRmv);

  // Next-state, handshake steering and beat counting for the single
  // outstanding command.
  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    active_d       = active_q;
    cnt_d          = cnt_q;
    ocmd_d         = ocmd_q;
    opaddr_d       = opaddr_q;
    CmdReady_o     = '0;
    DataInReady_o  = '0;
    DataOutValid_o = '0;
    OCmdValid_o    = 1'b0;
    OStoreValid_o  = 1'b0;
    OLoadReady_o   = 1'b0;
    beat_fire      = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          CmdReady_o[grant_idx] = 1'b1;
          ocmd_d   = Cmd_i[grant_idx*BECMDWidth +: BECMDWidth];
          opaddr_d = PAddr_i[grant_idx*ORAMU +: ORAMU];
          active_d = grant_idx;
          ptr_d    = (grant_idx == LastPort) ? '0 : grant_idx + 1'b1;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        OCmdValid_o = 1'b1;
        if (OCmdReady_i) begin
          cnt_d   = '0;
          state_d = is_load ? LOAD : STORE;
        end
      end
      STORE: begin
        OStoreValid_o           = DataInValid_i[active_q];
        DataInReady_o[active_q] = OStoreReady_i;
        beat_fire               = DataInValid_i[active_q] & OStoreReady_i;
      end
      LOAD: begin
        DataOutValid_o[active_q] = OLoadValid_i;
        OLoadReady_o             = DataOutReady_i[active_q];
        beat_fire                = OLoadValid_i & DataOutReady_i[active_q];
      end
      default: state_d = IDLE;
    endcase
    if (beat_fire) begin
      if (cnt_q == LastBeat) begin
        cnt_d   = '0;
        state_d = IDLE;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Data paths are pure passthrough; only the valid/ready steering is gated.
  assign OStoreData_o = DataIn_i[active_q*FEDWidth +: FEDWidth];
  assign DataOut_o    = OLoadData_i;
  assign OCmd_o       = ocmd_q;
  assign OPAddr_o     = opaddr_q;
  assign ActivePort_o = active_q;
  assign Busy_o       = (state_q != IDLE);

  // State registers; reset abandons any in-flight block.
  always_ff @(posedge Clock_i or negedge Reset_ni) begin
    if (!Reset_ni) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      active_q <= '0;
      cnt_q    <= '0;
      ocmd_q   <= '0;
      opaddr_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      active_q <= active_d;
      cnt_q    <= cnt_d;
      ocmd_q   <= ocmd_d;
      opaddr_q <= opaddr_d;
    end
  end

endmodule
